// File: rtl/neuro_pkg.sv
// ---------------------------------------------------------------------------
// neuro_pkg
// Shared definitions for the neuron accumulation sequencer:
//   - default sample / accumulator widths
//   - FSM state encoding (legacy-compatible localparam constants)
// ---------------------------------------------------------------------------
package neuro_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int ACC_W_DEF  = 28;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_CLEAR  = 3'd1;
   localparam logic [ST_W-1:0] ST_ACCUM  = 3'd2;
   localparam logic [ST_W-1:0] ST_SETTLE = 3'd3;
   localparam logic [ST_W-1:0] ST_OUTPUT = 3'd4;

endpackage

// File: rtl/neuron_acc_seq.sv
// ---------------------------------------------------------------------------
// neuron_acc_seq
// Sequences one neuron evaluation over an external registered accumulator:
// clears it, streams N_IN signed samples into it, waits one cycle for the
// final sum to settle, then presents the (optionally rectified) result.
//
// Configuration macro: NEURO_RELU_EN
//   defined     -> negative sums are reported as zero
//   not defined -> the accumulator sum is reported unchanged
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to begin an evaluation
//   abort      in   cancel the running evaluation
//   in_valid   in   input sample available
//   in_data    in   input sample (two's complement, DATA_W)
//   in_ready   out  sample accepted this cycle
//   acc_clr    out  clear strobe to the accumulator
//   acc_ce     out  accumulate enable to the accumulator
//   acc_a      out  addend to the accumulator
//   acc_y      in   registered accumulator sum (ACC_W)
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out_data   out  evaluation result (ACC_W)
//   busy       out  sequencer not idle
//   count      out  samples accepted in the current evaluation
// ---------------------------------------------------------------------------
module neuron_acc_seq
   import neuro_pkg::*;
#(
   parameter int N_IN   = 16,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   localparam int CNT_W = $clog2(N_IN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              acc_clr,
   output logic              acc_ce,
   output logic [DATA_W-1:0] acc_a,
   input  logic [ACC_W-1:0]  acc_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              busy,
   output logic [CNT_W-1:0]  count
);

   logic [ST_W-1:0]  r_state;
   logic [ST_W-1:0]  w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [ACC_W-1:0] r_out_data;
   logic             w_abort;
   logic             w_hs;
   logic             w_count_last;
   logic             w_out_hs;

   // Result shaping applied when the settled sum is captured.
   function automatic logic [ACC_W-1:0] f_result(input logic [ACC_W-1:0] y);
`ifdef NEURO_RELU_EN
      if (y[ACC_W-1]) begin
         return {ACC_W{1'b0}};
      end else begin
         return y;
      end
`else
      return y;
`endif
   endfunction

   // Abort only has meaning once an evaluation is running.
   assign w_abort      = abort & (r_state != ST_IDLE);

   // Outputs are forced to their reset values combinationally while rst is
   // high, so they are correct from the very first reset cycle rather than
   // one edge later. An abort suppresses in_ready/out_valid in the same
   // cycle so no sample or result slips through on the cancelling cycle.
   assign in_ready     = (r_state == ST_ACCUM) & ~abort & ~rst;
   assign acc_ce       = in_ready & in_valid;
   assign acc_a        = in_data;
   assign acc_clr      = rst | (r_state == ST_CLEAR);
   assign out_valid    = (r_state == ST_OUTPUT) & ~abort & ~rst;
   assign busy         = (r_state != ST_IDLE) & ~rst;
   assign out_data     = rst ? {ACC_W{1'b0}} : r_out_data;
   assign count        = rst ? {CNT_W{1'b0}} : r_count;

   assign w_hs         = acc_ce;
   assign w_count_last = (r_count == CNT_W'(N_IN - 1));
   assign w_out_hs     = out_valid & out_ready;

   // Next-state decode; abort overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_CLEAR;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            w_state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (w_hs && w_count_last) begin
               w_state_nxt = ST_SETTLE;
            end else begin
               w_state_nxt = ST_ACCUM;
            end
         end
         ST_SETTLE: begin
            w_state_nxt = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (w_out_hs) begin
               // Back-to-back evaluations: a start on the accepting cycle
               // goes straight to CLEAR without an idle bubble.
               if (start) begin
                  w_state_nxt = ST_CLEAR;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_state_nxt = ST_OUTPUT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Accepted-sample counter: cleared on CLEAR or abort, bumped per handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= {CNT_W{1'b0}};
      end else if (w_abort || (r_state == ST_CLEAR)) begin
         r_count <= {CNT_W{1'b0}};
      end else if (w_hs) begin
         r_count <= r_count + CNT_W'(1);
      end else begin
         r_count <= r_count;
      end
   end

   // Result capture at the end of SETTLE, when acc_y holds the final sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data <= {ACC_W{1'b0}};
      end else if ((r_state == ST_SETTLE) && !w_abort) begin
         r_out_data <= f_result(acc_y);
      end else begin
         r_out_data <= r_out_data;
      end
   end

endmodule
